// File: rtl/fifo_read_gearbox_10to6.sv
// Read-domain gearbox that drains 10-bit FIFO words and emits 6-bit 64-QAM symbols.
// The bit buffer is MSB-first and left-aligned: the oldest bit sits at bit_buf[BUF_W-1].
module fifo_read_gearbox_10to6 #(
  parameter int unsigned BUF_W = 24,
  parameter int unsigned CNT_W = 16
) (
  input  logic             read_clk,
  input  logic             read_rst,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [9:0]       fifo_data_out,
  output logic             fifo_read_enable,
  input  logic             sym_ready,
  output logic             sym_valid,
  output logic [5:0]       sym_data,
  output logic [4:0]       bit_count,
  output logic [CNT_W-1:0] words_read,
  output logic [CNT_W-1:0] syms_sent
);

  localparam int unsigned WORD_W = 10;
  localparam int unsigned SYM_W  = 6;
  // Wide enough for BUF_W plus the two words of look-ahead in the request test.
  localparam int unsigned CW     = 7;

  logic [BUF_W-1:0] bit_buf;
  logic [BUF_W-1:0] buf_shift;
  logic [BUF_W-1:0] buf_nxt;
  logic [BUF_W-1:0] word_ext;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_pop;
  logic [CW-1:0]    cnt_nxt;
  logic             pending;
  logic             drop;
  logic             pop;
  logic             push;

  // Next-state of the bit buffer and the read request, which looks ahead at this cycle's pop/push.
  always_comb begin
    pop       = sym_valid & sym_ready & ~flush;
    push      = pending & ~drop & ~flush;
    cnt_pop   = pop  ? (cnt - CW'(SYM_W))      : cnt;
    cnt_nxt   = push ? (cnt_pop + CW'(WORD_W)) : cnt_pop;
    fifo_read_enable = ~read_rst & enable & ~flush & ~fifo_empty &
                       ((cnt_nxt + CW'(WORD_W)) <= CW'(BUF_W));
    buf_shift = pop ? (bit_buf << SYM_W) : bit_buf;
    word_ext  = {fifo_data_out, {(BUF_W-WORD_W){1'b0}}};
    // Bits below cnt are kept zero, so an OR appends the word behind the survivors.
    buf_nxt   = push ? (buf_shift | (word_ext >> cnt_pop)) : buf_shift;
    if (flush) begin
      cnt_nxt = '0;
      buf_nxt = '0;
    end
  end

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      bit_buf    <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      drop       <= 1'b0;
      words_read <= '0;
      syms_sent  <= '0;
      sym_valid  <= 1'b0;
      sym_data   <= '0;
    end else begin
      bit_buf    <= buf_nxt;
      cnt        <= cnt_nxt;
      pending    <= fifo_read_enable;
      drop       <= flush & pending;
      if (push) words_read <= words_read + CNT_W'(1);
      if (pop)  syms_sent  <= syms_sent + CNT_W'(1);
      // Symbol outputs are registered from the next buffer state so they depend on no input.
      sym_valid  <= (cnt_nxt >= CW'(SYM_W));
      sym_data   <= (cnt_nxt >= CW'(SYM_W)) ? buf_nxt[BUF_W-1 -: SYM_W] : '0;
    end
  end

  assign bit_count = 5'(cnt);

endmodule

// File: tb/tb_fifo_read_gearbox_10to6.sv
// Directed bench for fifo_read_gearbox_10to6 with a 1-cycle-latency FIFO model.
module tb_fifo_read_gearbox_10to6;

  logic        read_clk;
  logic        read_rst;
  logic        enable;
  logic        flush;
  logic        fifo_empty;
  logic [9:0]  fifo_data_out;
  logic        fifo_read_enable;
  logic        sym_ready;
  logic        sym_valid;
  logic [5:0]  sym_data;
  logic [4:0]  bit_count;
  logic [15:0] words_read;
  logic [15:0] syms_sent;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       hold_empty;
  logic       clr_req;
  logic       rd_flag = 1'b0;
  logic [5:0] got_syms [$];
  bit         exp_bits [$];

  fifo_read_gearbox_10to6 #(.BUF_W(24), .CNT_W(16)) dut (
    .read_clk         (read_clk),
    .read_rst         (read_rst),
    .enable           (enable),
    .flush            (flush),
    .fifo_empty       (fifo_empty),
    .fifo_data_out    (fifo_data_out),
    .fifo_read_enable (fifo_read_enable),
    .sym_ready        (sym_ready),
    .sym_valid        (sym_valid),
    .sym_data         (sym_data),
    .bit_count        (bit_count),
    .words_read       (words_read),
    .syms_sent        (syms_sent)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  assign fifo_empty = hold_empty | (rd_ptr == wr_ptr);

  // Sample request and symbol handshakes mid-cycle, where all inputs are settled.
  always @(negedge read_clk) begin
    rd_flag = (fifo_read_enable === 1'b1);
    if (sym_valid === 1'b1 && sym_ready === 1'b1 && flush === 1'b0 && read_rst === 1'b0)
      got_syms.push_back(sym_data);
  end

  // FIFO model: data appears the cycle after the read strobe.
  initial fifo_data_out = '0;
  always @(posedge read_clk) begin
    if (clr_req) rd_ptr <= wr_ptr;
    else if (rd_flag) begin
      fifo_data_out <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic load_word(input logic [9:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
    for (int b = 9; b >= 0; b--) exp_bits.push_back(w[b]);
  endtask

  task automatic push_exp(input logic [9:0] w);
    for (int b = 9; b >= 0; b--) exp_bits.push_back(w[b]);
  endtask

  function automatic logic [5:0] pop_exp();
    logic [5:0] s;
    for (int i = 5; i >= 0; i--) s[i] = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'b0;
    return s;
  endfunction

  task automatic do_reset();
    read_rst = 1'b1; enable = 1'b0; flush = 1'b0; sym_ready = 1'b0;
    hold_empty = 1'b1; clr_req = 1'b1;
    tick();
    tick();
    clr_req = 1'b0;
    exp_bits.delete();
  endtask

  task automatic test_reset();
    load_word(10'h123);
    load_word(10'h321);
    hold_empty = 1'b0; enable = 1'b1; sym_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge read_clk);
      n_checks += 6;
      if (fifo_read_enable !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fifo_read_enable); end
      if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sym_valid); end
      if (sym_data !== 6'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", sym_data); end
      if (bit_count !== 5'd0) begin n_fail++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
      if (words_read !== 16'd0) begin n_fail++; $display("FAIL reset_words_read: got %0d expected 0", words_read); end
      if (syms_sent !== 16'd0) begin n_fail++; $display("FAIL reset_syms_sent: got %0d expected 0", syms_sent); end
    end
  endtask

  task automatic test_pattern();
    logic [5:0] e [0:4];
    int base;
    e = '{6'h3F, 6'h3C, 6'h00, 6'h0A, 6'h2A};
    do_reset();
    load_word(10'h3FF); load_word(10'h000); load_word(10'h2AA);
    base = got_syms.size();
    read_rst = 1'b0; hold_empty = 1'b0; enable = 1'b1; sym_ready = 1'b1;
    repeat (20) tick();
    n_checks += 4;
    if (got_syms.size() - base !== 5) begin n_fail++; $display("FAIL pattern_count: got %0d expected 5", got_syms.size() - base); end
    if (words_read !== 16'd3) begin n_fail++; $display("FAIL pattern_words_read: got %0d expected 3", words_read); end
    if (syms_sent !== 16'd5) begin n_fail++; $display("FAIL pattern_syms_sent: got %0d expected 5", syms_sent); end
    if (bit_count !== 5'd0) begin n_fail++; $display("FAIL pattern_bit_count: got %0d expected 0", bit_count); end
    for (int i = 0; i < 5 && base + i < got_syms.size(); i++) begin
      n_checks++;
      if (got_syms[base+i] !== e[i]) begin n_fail++; $display("FAIL pattern_sym[%0d]: got %h expected %h", i, got_syms[base+i], e[i]); end
    end
  endtask

  task automatic test_stream();
    int base;
    logic [5:0] e;
    do_reset();
    for (int i = 0; i < 40; i++) load_word(10'(i * 37 + 5));
    base = got_syms.size();
    read_rst = 1'b0; hold_empty = 1'b0; enable = 1'b1; sym_ready = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      @(negedge read_clk);
      if (c == 0) begin
        n_checks++;
        if (fifo_read_enable !== 1'b1) begin n_fail++; $display("FAIL stream_first_read: got %b expected 1", fifo_read_enable); end
      end
      if (c >= 2) begin
        n_checks++;
        if (sym_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid c%0d: got %b expected 1", c, sym_valid); end
      end
      n_checks++;
      if (bit_count > 5'd24) begin n_fail++; $display("FAIL stream_bit_count c%0d: got %0d expected <=24", c, bit_count); end
      if (c == 22) begin
        n_checks += 3;
        if (words_read !== 16'd13) begin n_fail++; $display("FAIL stream_words_read: got %0d expected 13", words_read); end
        if (syms_sent !== 16'd20) begin n_fail++; $display("FAIL stream_syms_sent: got %0d expected 20", syms_sent); end
        if (bit_count !== 5'd10) begin n_fail++; $display("FAIL stream_final_bits: got %0d expected 10", bit_count); end
      end
      tick();
    end
    n_checks++;
    if (got_syms.size() - base !== 21) begin n_fail++; $display("FAIL stream_count: got %0d expected 21", got_syms.size() - base); end
    for (int i = base; i < got_syms.size(); i++) begin
      e = pop_exp();
      n_checks++;
      if (got_syms[i] !== e) begin n_fail++; $display("FAIL stream_sym[%0d]: got %h expected %h", i - base, got_syms[i], e); end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] w [0:7];
    logic [5:0] e;
    int base;
    int reads;
    w = '{10'h2B7, 10'h0F0, 10'h155, 10'h3A1, 10'h04C, 10'h1E9, 10'h333, 10'h2C8};
    do_reset();
    for (int i = 0; i < 8; i++) load_word(w[i]);
    base = got_syms.size();
    reads = 0;
    read_rst = 1'b0; hold_empty = 1'b0; enable = 1'b1; sym_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge read_clk);
      if (fifo_read_enable === 1'b1) reads++;
      if (c >= 3) begin
        n_checks += 3;
        if (bit_count !== 5'd20) begin n_fail++; $display("FAIL bp_bit_count c%0d: got %0d expected 20", c, bit_count); end
        if (sym_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %b expected 1", c, sym_valid); end
        if (sym_data !== w[0][9:4]) begin n_fail++; $display("FAIL bp_hold c%0d: got %h expected %h", c, sym_data, w[0][9:4]); end
      end
      tick();
    end
    n_checks++;
    if (reads !== 2) begin n_fail++; $display("FAIL bp_reads: got %0d expected 2", reads); end
    sym_ready = 1'b1;
    repeat (40) tick();
    n_checks += 4;
    if (got_syms.size() - base !== 13) begin n_fail++; $display("FAIL bp_count: got %0d expected 13", got_syms.size() - base); end
    if (words_read !== 16'd8) begin n_fail++; $display("FAIL bp_words_read: got %0d expected 8", words_read); end
    if (syms_sent !== 16'd13) begin n_fail++; $display("FAIL bp_syms_sent: got %0d expected 13", syms_sent); end
    if (bit_count !== 5'd2) begin n_fail++; $display("FAIL bp_residual: got %0d expected 2", bit_count); end
    for (int i = base; i < got_syms.size(); i++) begin
      e = pop_exp();
      n_checks++;
      if (got_syms[i] !== e) begin n_fail++; $display("FAIL bp_sym[%0d]: got %h expected %h", i - base, got_syms[i], e); end
    end
  endtask

  task automatic test_flush();
    logic [9:0] w [0:5];
    logic [5:0] e;
    int base;
    w = '{10'h2D3, 10'h1A5, 10'h3C0, 10'h0F1, 10'h255, 10'h38E};
    do_reset();
    for (int i = 0; i < 6; i++) load_word(w[i]);
    exp_bits.delete();
    for (int i = 3; i < 6; i++) push_exp(w[i]);
    base = got_syms.size();
    read_rst = 1'b0; hold_empty = 1'b0; enable = 1'b1; sym_ready = 1'b1;
    repeat (3) tick();
    flush = 1'b1;
    @(negedge read_clk);
    n_checks += 2;
    if (bit_count !== 5'd14) begin n_fail++; $display("FAIL flush_pre_bits: got %0d expected 14", bit_count); end
    if (fifo_read_enable !== 1'b0) begin n_fail++; $display("FAIL flush_no_read: got %b expected 0", fifo_read_enable); end
    tick();
    flush = 1'b0;
    @(negedge read_clk);
    n_checks += 4;
    if (bit_count !== 5'd0) begin n_fail++; $display("FAIL flush_bits: got %0d expected 0", bit_count); end
    if (words_read !== 16'd2) begin n_fail++; $display("FAIL flush_words_read: got %0d expected 2", words_read); end
    if (syms_sent !== 16'd1) begin n_fail++; $display("FAIL flush_syms_sent: got %0d expected 1", syms_sent); end
    if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", sym_valid); end
    repeat (20) tick();
    n_checks += 4;
    if (got_syms.size() - base !== 6) begin n_fail++; $display("FAIL flush_count: got %0d expected 6", got_syms.size() - base); end
    if (words_read !== 16'd5) begin n_fail++; $display("FAIL flush_words_final: got %0d expected 5", words_read); end
    if (syms_sent !== 16'd6) begin n_fail++; $display("FAIL flush_syms_final: got %0d expected 6", syms_sent); end
    if (bit_count !== 5'd0) begin n_fail++; $display("FAIL flush_bits_final: got %0d expected 0", bit_count); end
    if (got_syms.size() > base) begin
      n_checks++;
      if (got_syms[base] !== w[0][9:4]) begin n_fail++; $display("FAIL flush_first_sym: got %h expected %h", got_syms[base], w[0][9:4]); end
    end
    for (int i = base + 1; i < got_syms.size(); i++) begin
      e = pop_exp();
      n_checks++;
      if (got_syms[i] !== e) begin n_fail++; $display("FAIL flush_sym[%0d]: got %h expected %h", i - base, got_syms[i], e); end
    end
  endtask

  task automatic test_alt_empty();
    logic [5:0] e;
    int base;
    do_reset();
    for (int i = 0; i < 12; i++) load_word(10'(i * 73 + 17));
    base = got_syms.size();
    read_rst = 1'b0; hold_empty = 1'b0; enable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      hold_empty = c[0];
      sym_ready  = (c < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge read_clk);
      n_checks++;
      if ((fifo_read_enable & fifo_empty) !== 1'b0) begin
        n_fail++; $display("FAIL alt_read_when_empty c%0d: got rd_en=%b empty=%b expected no read", c, fifo_read_enable, fifo_empty);
      end
      tick();
    end
    n_checks += 4;
    if (got_syms.size() - base !== 20) begin n_fail++; $display("FAIL alt_count: got %0d expected 20", got_syms.size() - base); end
    if (words_read !== 16'd12) begin n_fail++; $display("FAIL alt_words_read: got %0d expected 12", words_read); end
    if (syms_sent !== 16'd20) begin n_fail++; $display("FAIL alt_syms_sent: got %0d expected 20", syms_sent); end
    if (bit_count !== 5'd0) begin n_fail++; $display("FAIL alt_bits: got %0d expected 0", bit_count); end
    for (int i = base; i < got_syms.size(); i++) begin
      e = pop_exp();
      n_checks++;
      if (got_syms[i] !== e) begin n_fail++; $display("FAIL alt_sym[%0d]: got %h expected %h", i - base, got_syms[i], e); end
    end
  endtask

  initial begin
    read_rst = 1'b1; enable = 1'b0; flush = 1'b0; sym_ready = 1'b0;
    hold_empty = 1'b1; clr_req = 1'b0;
    test_reset();
    test_pattern();
    test_stream();
    test_backpressure();
    test_flush();
    test_alt_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
